// File: rtl/roi_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : roi_writer_if
// Brief    : Pixel stream, ROI buffer write port and buffer ownership signals
//            between the ROI writer and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface roi_writer_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 6
);
    logic              start;
    logic [PIX_W-1:0]  pix_in;
    logic              pix_valid;
    logic              pix_sof;
    logic              pix_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              frame_done;
    logic              buf_full;
    logic              rd_release;
    logic [7:0]        sync_err;

    modport master (
        input  start, pix_in, pix_valid, pix_sof, rd_release,
        output pix_ready, wr_en, wr_addr, wr_data, frame_done, buf_full, sync_err
    );

    modport slave (
        output start, pix_in, pix_valid, pix_sof, rd_release,
        input  pix_ready, wr_en, wr_addr, wr_data, frame_done, buf_full, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/roi_writer.sv
`default_nettype none
// ============================================================================
// Module   : roi_writer
// Brief    : Fills the ROI buffer from a raster pixel stream and hands it to
//            the reader until released.
// Revision : 1.0 - initial release
// ============================================================================
module roi_writer #(
    parameter int ROI_DEPTH = 6,
    parameter int ROI_WIDTH = 6,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = $clog2(ROI_DEPTH*ROI_WIDTH)
) (
    input  wire             clk,
    input  wire             reset,
    roi_writer_if.master    bus
);
    localparam int                c_NPIX = ROI_DEPTH*ROI_WIDTH;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_NPIX-1);
    localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;
    logic              r_frame_done;
    logic [7:0]        r_sync_err;

    logic              w_accept;
    logic              w_resync;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;
    logic              w_enter_fill;

    assign w_accept     = (r_state == S_FILL) && bus.pix_valid;
    // A mid-frame start-of-frame restarts the frame with this pixel at 0
    assign w_resync     = w_accept && bus.pix_sof && (r_idx != '0);
    assign w_addr       = w_resync ? '0 : r_idx;
    assign w_last       = w_accept && (w_addr == c_LAST);
    assign w_enter_fill = (r_state != S_FILL) && (w_state_nxt == S_FILL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_FILL;
            S_FILL:  if (w_last) w_state_nxt = S_HOLD;
            S_HOLD:  if (bus.rd_release) w_state_nxt = bus.start ? S_FILL : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 8'd0;
        end else begin
            r_wr_en      <= w_accept;
            r_frame_done <= w_last;
            if (w_accept) begin
                r_wr_addr <= w_addr;
                r_wr_data <= bus.pix_in;
            end
            if (w_resync && (r_sync_err != 8'hFF)) begin
                r_sync_err <= r_sync_err + 8'd1;
            end
            if (w_enter_fill) begin
                r_idx <= '0;
            end else if (w_accept) begin
                if (w_resync) begin
                    r_idx <= c_ONE;
                end else if (w_last) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + c_ONE;
                end
            end
        end
    end

    assign bus.pix_ready  = (r_state == S_FILL);
    assign bus.buf_full   = (r_state == S_HOLD);
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_done = r_frame_done;
    assign bus.sync_err   = r_sync_err;
endmodule
`default_nettype wire

// File: tb/tb_roi_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_roi_writer
// Brief    : Directed self-checking bench for roi_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_roi_writer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   exp_sync;

    roi_writer_if #(.PIX_W(8), .ADDR_W(6)) bus ();

    roi_writer #(
        .ROI_DEPTH(6),
        .ROI_WIDTH(6),
        .PIX_W    (8),
        .ADDR_W   (6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start", {bus.pix_ready, bus.buf_full, bus.wr_en}, 3'b100);
    endtask

    // Drives one frame from idx 0; the address/data/flag expectations follow
    // the linear-index rules including resync at pixel number resync_at.
    task automatic fill_frame(input logic [7:0] base, input int resync_at,
                              input bit gaps, input bit sof_first, input int n_limit);
        int         idx;
        int         k;
        bit         last;
        logic       sof;
        logic [5:0] a;
        logic [7:0] d;
        idx  = 0;
        k    = 0;
        last = 1'b0;
        while (!last && (k < n_limit)) begin
            sof = ((k == 0) && sof_first) || (k == resync_at);
            if (sof && (idx != 0)) begin
                a   = 6'd0;
                idx = 1;
                if (exp_sync < 255) exp_sync++;
            end else begin
                a   = idx[5:0];
                idx = idx + 1;
            end
            d    = base + k[7:0];
            last = (a == 6'd35);
            bus.pix_valid = 1'b1;
            bus.pix_in    = d;
            bus.pix_sof   = sof;
            tick();
            check("write",
                  {bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done,
                   bus.buf_full, bus.pix_ready, bus.sync_err},
                  {1'b1, a, d, last, last, !last, exp_sync[7:0]});
            k++;
            if (gaps && !last) begin
                bus.pix_valid = 1'b0;
                bus.pix_sof   = 1'b0;
                bus.pix_in    = 8'hEE;
                tick();
                check("gap", {bus.wr_en, bus.frame_done, bus.pix_ready}, 3'b001);
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic end_frame();
        tick();
        check("hold", {bus.wr_en, bus.frame_done, bus.buf_full, bus.pix_ready}, 4'b0010);
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        check("release", {bus.wr_en, bus.buf_full, bus.pix_ready}, 3'b000);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        exp_sync       = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.pix_in     = 8'h00;
        bus.pix_valid  = 1'b0;
        bus.pix_sof    = 1'b0;
        bus.rd_release = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              {bus.pix_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
               bus.frame_done, bus.buf_full, bus.sync_err}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_ready", {bus.pix_ready, bus.buf_full}, 2'b00);

        // Full-rate frame, data equals address
        start_frame();
        fill_frame(8'h00, -1, 1'b0, 1'b1, 100);
        tick();
        check("hold_after_frame", {bus.wr_en, bus.frame_done, bus.buf_full, bus.pix_ready}, 4'b0010);

        // start alone in HOLD is ignored, even with pixels offered
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'h99;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("hold_start_ignored", {bus.wr_en, bus.buf_full, bus.pix_ready}, 3'b010);
        tick();
        check("hold_no_write", {bus.wr_en, bus.buf_full, bus.pix_ready}, 3'b010);
        bus.pix_valid  = 1'b0;
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        check("release_idle", {bus.wr_en, bus.buf_full, bus.pix_ready}, 3'b000);
        tick();
        check("idle_stays", {bus.wr_en, bus.buf_full, bus.pix_ready}, 3'b000);

        // Stalled frame, no sof at idx 0 is not an error
        start_frame();
        fill_frame(8'h40, -1, 1'b1, 1'b0, 100);
        end_frame();

        // Resync at idx 10, repeated until the counter saturates
        for (int f = 0; f < 300; f++) begin
            start_frame();
            fill_frame(8'h80, 10, 1'b0, 1'b1, 100);
            end_frame();
        end
        check("sync_err_saturated", {24'd0, bus.sync_err}, 32'd255);

        // Release and start together: straight back into FILL
        start_frame();
        fill_frame(8'hC0, -1, 1'b0, 1'b1, 100);
        tick();
        check("hold_before_restart", {bus.buf_full, bus.pix_ready}, 2'b10);
        bus.rd_release = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        bus.start      = 1'b0;
        check("release_start", {bus.buf_full, bus.pix_ready, bus.wr_en}, 3'b010);
        fill_frame(8'h20, -1, 1'b0, 1'b1, 100);
        end_frame();

        // Reset mid-fill at idx 20 with a pixel offered in the reset cycle
        start_frame();
        fill_frame(8'h10, -1, 1'b0, 1'b1, 20);
        reset         = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'hAA;
        tick();
        exp_sync = 0;
        check("reset_mid_fill",
              {bus.pix_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
               bus.frame_done, bus.buf_full, bus.sync_err}, 32'd0);
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        tick();
        check("post_reset_idle", {bus.wr_en, bus.pix_ready, bus.buf_full}, 3'b000);
        start_frame();
        fill_frame(8'h50, -1, 1'b0, 1'b1, 100);
        end_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/roi_writer.md
# roi_writer

Fills the ROI buffer that the mosaic pipeline reads. Accepts a raster-order pixel stream over a valid/ready handshake, writes ROI_DEPTH×ROI_WIDTH pixels into the buffer's write port at linear addresses, then hands the buffer to the reader side until the reader releases it. It is the producer end of the ROI buffer interface consumed by `pipeline`.

## Interface
- ROI_DEPTH, 6, ROI rows.
- ROI_WIDTH, 6, ROI columns.
- PIX_W, 8, pixel width in bits.
- ADDR_W, $clog2(ROI_DEPTH*ROI_WIDTH), buffer address width (derived; 6 at defaults).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin filling the buffer.
- pix_in  in  PIX_W  pixel data.
- pix_valid  in  1  pix_in is valid.
- pix_sof  in  1  start-of-frame marker, qualified by pix_valid.
- pix_ready  out  1  writer accepts a pixel this cycle.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address, row*ROI_WIDTH+col.
- wr_data  out  PIX_W  buffer write data.
- frame_done  out  1  one-cycle pulse: buffer is complete.
- buf_full  out  1  level: buffer is owned by the reader.
- rd_release  in  1  reader has finished; the buffer is free.
- sync_err  out  8  saturating count of resync events.

## Operation
- States: IDLE, FILL, HOLD.
- IDLE:
  - pix_ready=0, buf_full=0.
  - start=1 → FILL, and the linear index idx is cleared to 0.
- FILL:
  - pix_ready=1. A pixel is accepted when pix_valid & pix_ready.
  - Each accepted pixel writes at address idx, then idx increments.
  - Resync: an accepted pixel with pix_sof=1 while idx≠0 is written at address 0, sets idx=1, and increments sync_err. sync_err saturates at 255.
  - pix_sof=1 at idx=0 is normal.
  - pix_sof=0 at idx=0 is accepted normally; no error.
  - When the pixel at idx=ROI_DEPTH*ROI_WIDTH−1 is accepted → HOLD. pix_ready is 0 from the next cycle on.
  - start during FILL is ignored.
  - rd_release during FILL is ignored.
- HOLD:
  - pix_ready=0, buf_full=1.
  - rd_release=1 → IDLE.
  - rd_release=1 and start=1 in the same cycle → FILL directly, with idx=0.
  - start alone is ignored.
- Arithmetic:
  - idx is ADDR_W bits and never exceeds ROI_DEPTH*ROI_WIDTH−1.
  - There is no wrap within a frame. Completion forces the exit from FILL.
- Reset (any state, including mid-FILL):
  - Go to IDLE; idx=0.
  - All outputs are 0: pix_ready, wr_en, wr_addr, wr_data, frame_done, buf_full, sync_err.
  - A write registered in the reset cycle is discarded, so wr_en=0 on the following cycle.
  - Buffer contents are not cleared.

## Timing
- pix_ready is a registered output derived from state. It goes to 1 the cycle after start is sampled in IDLE.
- Write latency is 1 cycle. A pixel accepted in cycle N gives wr_en=1 in N+1, with wr_addr/wr_data held from cycle N.
- wr_en=0 in all other cycles.
- Full rate: back-to-back accepted pixels produce back-to-back writes.
- Stalls: pix_valid=0 gaps produce wr_en=0 gaps, and idx holds.
- Last pixel accepted in cycle N:
  - N+1: last write (wr_en=1), frame_done=1, buf_full=1, pix_ready=0.
  - frame_done is high for exactly one cycle.
- Minimum fill time at full rate: ROI_DEPTH*ROI_WIDTH+1 cycles from the start sample to frame_done (37 at defaults).
- rd_release sampled in cycle M (in HOLD):
  - buf_full=0 in M+1.
  - If start was also high in M, pix_ready=1 in M+1.

## Test plan
- Reset, then start with 36 back-to-back pixels 0x00..0x23 and pix_sof on the first → writes at addr 0..35 with data = addr, contiguous wr_en. frame_done is a single pulse on the write to addr 35, and buf_full=1.
- In HOLD, drive pix_valid=1 and pulse start alone → pix_ready stays 0, no writes. Then rd_release → buf_full=0 the next cycle, state IDLE.
- pix_valid toggling 1,0,1,0 across a frame → wr_en mirrors accepts one cycle later. Addresses are still 0..35, frame_done appears only after the 36th accept.
- pix_sof on the 11th pixel (idx=10) → that pixel is written at addr 0, the next at addr 1, and sync_err=1. frame_done comes after 35 further pixels. Repeated 300 times, sync_err saturates at 255.
- rd_release and start in the same HOLD cycle → buf_full=0 and pix_ready=1 the next cycle, and the new frame writes from addr 0.
- reset asserted at idx=20 mid-FILL → the next cycle has all outputs 0 and no wr_en. A subsequent start and 36 pixels complete normally from addr 0.
